// File: rtl/music_pkg.sv
// Shared types and defaults for the track-switch controller and its debouncer.
package music_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CLEAR  = 2'd2
  } state_e;

  localparam int TRACK_W_DEF    = 2;
  localparam int STABLE_CYC_DEF = 4;
  localparam int CLR_LEN_DEF    = 2;
  localparam int CNT_W_DEF      = 8;

  // Bits needed to count from 0 up to and including n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sel_debounce.sv
// Holds the candidate selection and its stable-sample count; flags the edge on which
// the candidate has been seen STABLE_CYC times in a row.
module sel_debounce
  import music_pkg::*;
#(
  parameter int TRACK_W    = TRACK_W_DEF,
  parameter int STABLE_CYC = STABLE_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               hold,
  input  logic [TRACK_W-1:0] sample,
  output logic [TRACK_W-1:0] candidate,
  output logic               stable_hit
);

  localparam int CW = cnt_width(STABLE_CYC);

  logic [TRACK_W-1:0] cand_reg;
  logic [CW-1:0]      count_reg;
  logic               same;
  logic               restart;

  assign same    = (sample == cand_reg);
  assign restart = load || (hold && !same);

  // Candidate as it stands after this edge; on a hit it is the value to commit.
  assign candidate = restart ? sample : cand_reg;

  always_comb begin
    stable_hit = 1'b0;
    if (load) begin
      stable_hit = (STABLE_CYC == 1);
    end else if (hold) begin
      stable_hit = same && ((count_reg + CW'(1)) == CW'(STABLE_CYC));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand_reg  <= '0;
      count_reg <= '0;
    end else if (restart) begin
      cand_reg  <= sample;
      count_reg <= CW'(1);
    end else if (hold) begin
      count_reg <= count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/track_switch_ctrl.sv
// Debounced track-change controller: commits a stable selection, strobes the counter
// clear for CLR_LEN cycles and mutes playback while a switch is pending or clearing.
module track_switch_ctrl
  import music_pkg::*;
#(
  parameter int TRACK_W    = TRACK_W_DEF,
  parameter int STABLE_CYC = STABLE_CYC_DEF,
  parameter int CLR_LEN    = CLR_LEN_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [TRACK_W-1:0] music_reg,
  output logic               cnt_clc,
  output logic [TRACK_W-1:0] track_cur,
  output logic               mute,
  output logic               play_en,
  output logic [CNT_W-1:0]   sw_count
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_SETTLE = SETTLE;
  localparam logic [1:0] S_CLEAR  = CLEAR;

  logic [1:0]         state_reg, state_next;
  logic [7:0]         clr_cnt_reg;
  logic [TRACK_W-1:0] track_cur_reg;
  logic [CNT_W-1:0]   sw_count_reg;
  logic               cnt_clc_reg;
  logic               mute_reg;

  logic               load, hold, commit, clr_end;
  logic               stable_hit;
  logic [TRACK_W-1:0] candidate;

  sel_debounce #(
    .TRACK_W   (TRACK_W),
    .STABLE_CYC(STABLE_CYC)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .hold      (hold),
    .sample    (music_reg),
    .candidate (candidate),
    .stable_hit(stable_hit)
  );

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    hold       = 1'b0;
    clr_end    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (music_reg != track_cur_reg) begin
          load       = 1'b1;
          state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (music_reg == track_cur_reg) state_next = S_IDLE;
        else                            hold       = 1'b1;
      end
      S_CLEAR: begin
        // The selection is only looked at once the strobe has run its full length.
        if (clr_cnt_reg == 8'd1) begin
          clr_end = 1'b1;
          if (music_reg == track_cur_reg) begin
            state_next = S_IDLE;
          end else begin
            load       = 1'b1;
            state_next = S_SETTLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
    commit = stable_hit;
    if (stable_hit) state_next = S_CLEAR;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      clr_cnt_reg   <= '0;
      track_cur_reg <= '0;
      sw_count_reg  <= '0;
      cnt_clc_reg   <= 1'b0;
      mute_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      mute_reg  <= (state_next != S_IDLE);
      if (commit) begin
        track_cur_reg <= candidate;
        sw_count_reg  <= sw_count_reg + CNT_W'(1);
        cnt_clc_reg   <= 1'b1;
        clr_cnt_reg   <= 8'(CLR_LEN);
      end else if (clr_end) begin
        cnt_clc_reg <= 1'b0;
        clr_cnt_reg <= '0;
      end else if (state_reg == S_CLEAR) begin
        clr_cnt_reg <= clr_cnt_reg - 8'd1;
      end
    end
  end

  assign cnt_clc   = cnt_clc_reg;
  assign track_cur = track_cur_reg;
  assign mute      = mute_reg;
  assign sw_count  = sw_count_reg;
  assign play_en   = (track_cur_reg != '0) && !mute_reg;

endmodule

// File: tb/tb_track_switch_ctrl.sv
// Scoreboard bench: stimulus queues expected clear strobes, a monitor checks each one.
module tb_track_switch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a, rst_n_b;
  logic [1:0] music_a, music_b;
  logic       clc  [2];
  logic       mute [2];
  logic       play [2];
  logic [1:0] trk  [2];
  logic [7:0] cnt  [2];
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  assign cnt[0] = cnt_a;
  assign cnt[1] = {6'd0, cnt_b};

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int dut;
    int cyc;
    int track;
    int count;
    int len;
  } exp_t;
  exp_t sb[$];

  track_switch_ctrl #(.TRACK_W(2), .STABLE_CYC(4), .CLR_LEN(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .music_reg(music_a), .cnt_clc(clc[0]),
    .track_cur(trk[0]), .mute(mute[0]), .play_en(play[0]), .sw_count(cnt_a)
  );

  track_switch_ctrl #(.TRACK_W(2), .STABLE_CYC(1), .CLR_LEN(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .music_reg(music_b), .cnt_clc(clc[1]),
    .track_cur(trk[1]), .mute(mute[1]), .play_en(play[1]), .sw_count(cnt_b)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_neg_cyc(input int t);
    forever begin
      @(negedge clk);
      if (cyc >= t) break;
    end
  endtask

  task automatic push(input int d, input int c, input int tr, input int cn, input int len);
    sb.push_back('{d, c, tr, cn, len});
  endtask

  task automatic sel_a(input logic [1:0] v, output int c);
    tick();
    music_a = v;
    c = cyc;
  endtask

  task automatic sel_b(input logic [1:0] v, output int c);
    tick();
    music_b = v;
    c = cyc;
  endtask

  task automatic chk_zero(input int i, input string tag);
    chk({tag, "_clc"},   int'(clc[i]),  0);
    chk({tag, "_mute"},  int'(mute[i]), 0);
    chk({tag, "_play"},  int'(play[i]), 0);
    chk({tag, "_track"}, int'(trk[i]),  0);
    chk({tag, "_count"}, int'(cnt[i]),  0);
  endtask

  // Monitor: every rising strobe pops one expectation; its length is checked on the fall.
  initial begin
    logic prev [2];
    int   run  [2];
    int   want [2];
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      prev[i] = 1'b0;
      run[i]  = 0;
      want[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (clc[i] && !prev[i]) begin
          if (sb.size() == 0) begin
            chk($sformatf("unexpected_strobe_dut%0d", i), 1, 0);
            want[i] = 0;
          end else begin
            e = sb.pop_front();
            chk("strobe_dut",  i,              e.dut);
            chk("strobe_cyc",  cyc,            e.cyc);
            chk("strobe_trk",  int'(trk[i]),   e.track);
            chk("strobe_cnt",  int'(cnt[i]),   e.count);
            want[i] = e.len;
          end
          run[i] = 1;
        end else if (clc[i]) begin
          run[i]++;
        end
        if (!clc[i] && prev[i]) chk($sformatf("strobe_len_dut%0d", i), run[i], want[i]);
        if (clc[i]) chk("mute_in_clear", int'(mute[i]), 1);
        prev[i] = clc[i];
      end
    end
  end

  initial begin
    int c, c1;
    int vals [5];
    int cnts [5];
    vals = '{1, 2, 3, 1, 2};
    cnts = '{1, 2, 3, 0, 1};
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    music_a = 2'd3;
    music_b = 2'd0;

    // Reset with a pending selection, then release: commit to 3 after 4 samples.
    tick();
    tick();
    @(negedge clk);
    chk_zero(0, "reset_a");
    chk_zero(1, "reset_b");
    tick();
    rst_n_a = 1'b1;
    c = cyc;
    push(0, c + 4, 3, 1, 2);
    repeat (8) tick();
    @(negedge clk);
    chk("first_trk",  int'(trk[0]),  3);
    chk("first_cnt",  int'(cnt[0]),  1);
    chk("first_mute", int'(mute[0]), 0);
    chk("first_play", int'(play[0]), 1);

    sel_a(2'd1, c);
    push(0, c + 4, 1, 2, 2);
    repeat (8) tick();

    // Glitch: two samples of 2 then back to 1.
    sel_a(2'd2, c);
    wait_neg_cyc(c + 1);
    chk("glitch_mute1", int'(mute[0]), 1);
    sel_a(2'd1, c1);
    wait_neg_cyc(c + 2);
    chk("glitch_mute2", int'(mute[0]), 1);
    wait_neg_cyc(c + 3);
    chk("glitch_mute3", int'(mute[0]), 0);
    repeat (4) tick();
    @(negedge clk);
    chk("glitch_cnt", int'(cnt[0]), 2);
    chk("glitch_trk", int'(trk[0]), 1);
    chk("glitch_play", int'(play[0]), 1);

    // Retarget: three samples of 2, then 3 held.
    sel_a(2'd2, c);
    tick();
    tick();
    sel_a(2'd3, c1);
    push(0, c1 + 4, 3, 3, 2);
    repeat (10) tick();
    @(negedge clk);
    chk("retarget_trk", int'(trk[0]), 3);
    chk("retarget_cnt", int'(cnt[0]), 3);

    // Change during the clear strobe: back-to-back switches with mute held.
    sel_a(2'd2, c);
    push(0, c + 4, 2, 4, 2);
    for (int k = 1; k <= 10; k++) begin
      wait_neg_cyc(c + k);
      chk($sformatf("b2b_mute_%0d", k), int'(mute[0]), 1);
      if (k == 4) begin
        sel_a(2'd1, c1);
        push(0, c1 + 4, 1, 5, 2);
      end
    end
    wait_neg_cyc(c + 11);
    chk("b2b_mute_end", int'(mute[0]), 0);
    chk("b2b_trk", int'(trk[0]), 1);
    chk("b2b_cnt", int'(cnt[0]), 5);

    // Reset during SETTLE.
    sel_a(2'd3, c);
    tick();
    tick();
    rst_n_a = 1'b0;
    music_a = 2'd0;
    wait_neg_cyc(c + 3);
    chk_zero(0, "rst_settle");
    tick();
    rst_n_a = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    chk_zero(0, "rst_settle_after");

    // Reset during CLEAR: strobe is cut to a single cycle.
    sel_a(2'd2, c);
    push(0, c + 4, 2, 1, 1);
    repeat (4) tick();
    rst_n_a = 1'b0;
    music_a = 2'd0;
    wait_neg_cyc(c + 5);
    chk_zero(0, "rst_clear");
    tick();
    rst_n_a = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    chk_zero(0, "rst_clear_after");

    // Single-sample debounce, one-cycle strobe, 2-bit wrapping counter.
    tick();
    rst_n_b = 1'b1;
    repeat (2) tick();
    for (int k = 0; k < 5; k++) begin
      sel_b(2'(vals[k]), c);
      push(1, c + 1, vals[k], cnts[k], 1);
      tick();
    end
    repeat (4) tick();
    @(negedge clk);
    chk("sweep_cnt", int'(cnt[1]), 1);
    chk("sweep_trk", int'(trk[1]), 2);
    chk("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
